// File: rtl/mu0_mem_ctrl.sv
// mu0 core-side memory controller: latches a request, waits WAIT_STATES cycles,
// strobes a synchronous SRAM once, then pulses ready. Option: MEM_ROM_PROTECT_EN.
module mu0_mem_ctrl #(
  parameter int                ADDR_W      = 12,
  parameter int                DATA_W      = 16,
  parameter int                WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] ROM_TOP     = ADDR_W'(12'h100)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memrq,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              ready,
  output logic              err,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        dbg_state
);

  // Handshake: memrq (with rnw/addr/wdata) is taken on any IDLE edge where it is
  // high; it is ignored until the next IDLE. ready is a single-cycle completion
  // pulse, and for reads rdata is valid from that cycle while rdata_oe stays high.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_ACCESS  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  state_t            state, state_n;
  logic [3:0]        cnt;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              blocked;

`ifdef MEM_ROM_PROTECT_EN
  assign blocked = ~rnw_q && (addr_q < ROM_TOP);
`else
  logic unused_rom_top;
  assign unused_rom_top = ^ROM_TOP;
  assign blocked        = 1'b0;
`endif

  assign dbg_state = state;
  assign ram_ce    = (state == S_ACCESS) && !blocked;
  assign ram_we    = ram_ce && !rnw_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (memrq) begin
          accept = 1'b1;
          if (WAIT_STATES != 0) state_n = S_WAIT;
          else                  state_n = S_ACCESS;
        end
      end
      S_WAIT:    if (cnt == 4'd0) state_n = S_ACCESS;
      S_ACCESS:  state_n = rnw_q ? S_CAPTURE : S_DONE;
      S_CAPTURE: state_n = S_DONE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      rnw_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata     <= '0;
      rdata_oe  <= 1'b0;
      ready     <= 1'b0;
      err       <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (accept) begin
        rnw_q    <= rnw;
        addr_q   <= addr;
        wdata_q  <= wdata;
        rdata_oe <= 1'b0;
        if (WAIT_STATES != 0) cnt <= WAIT_INIT;
      end
      if (state == S_WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      // With zero wait states ACCESS follows acceptance directly, so bypass the latches.
      if (state_n == S_ACCESS) begin
        ram_addr  <= accept ? addr  : addr_q;
        ram_wdata <= accept ? wdata : wdata_q;
      end
      if (state == S_CAPTURE) rdata <= ram_rdata;
      if (state_n == S_DONE) begin
        ready    <= 1'b1;
        err      <= blocked;
        rdata_oe <= rnw_q;
      end
    end
  end

endmodule

// File: tb/tb_mu0_mem_ctrl.sv
// Self-checking bench for mu0_mem_ctrl: SRAM model, transaction-level reference
// memory, read-data scoreboard, directed and randomized transactions.
module tb_mu0_mem_ctrl;

  localparam int                WS      = 1;
  localparam logic [11:0]       ROM_TOP = 12'h100;

  logic        clk;
  logic        reset;
  logic        memrq;
  logic        rnw;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rdata_oe;
  logic        ready;
  logic        err;
  logic        ram_ce;
  logic        ram_we;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [2:0]  dbg_state;

  logic [15:0] sram    [4096];
  logic [15:0] ref_mem [4096];
  logic [15:0] exp_q[$];

  int n_checks;
  int n_pass;

  mu0_mem_ctrl #(
    .ADDR_W(12), .DATA_W(16), .WAIT_STATES(WS), .ROM_TOP(ROM_TOP)
  ) dut (
    .clk(clk), .reset(reset), .memrq(memrq), .rnw(rnw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_oe(rdata_oe), .ready(ready),
    .err(err), .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous SRAM: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) sram[ram_addr] <= ram_wdata;
      else        ram_rdata      <= sram[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Called on a negedge while the DUT is IDLE; returns on the next IDLE negedge.
  task automatic do_txn(input logic r, input logic [11:0] a, input logic [15:0] d,
                        input logic drop);
    int          ce_cnt, ce_at, done_at, exp_lat;
    logic        we_s, oe_done, err_s, blk;
    logic [11:0] ra;
    logic [15:0] rw, rd, exp_rd;
    blk = 1'b0;
`ifdef MEM_ROM_PROTECT_EN
    blk = !r && (a < ROM_TOP);
`endif
    exp_lat = r ? 3 + WS : 2 + WS;
    memrq = 1'b1; rnw = r; addr = a; wdata = d;
    if (r) exp_q.push_back(ref_mem[a]);
    else if (!blk) ref_mem[a] = d;
    @(posedge clk);
    ce_cnt = 0; ce_at = -1; done_at = -1;
    we_s = 1'b0; oe_done = 1'b0; err_s = 1'b0; ra = '0; rw = '0; rd = '0;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("oe_clear_on_accept", rdata_oe, 0);
        if (drop) begin
          memrq = 1'b0; addr = ~a; wdata = ~d; rnw = ~r;
        end
      end
      if (ram_ce) begin
        ce_cnt++; ce_at = i; we_s = ram_we; ra = ram_addr; rw = ram_wdata;
      end
      if (ready) begin
        done_at = i; oe_done = rdata_oe; err_s = err; rd = rdata;
      end
    end
    if (done_at < 0) begin
      check("ready_timeout", 0, 1);
      if (r) exp_rd = exp_q.pop_front();
      reset = 1'b0; memrq = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      return;
    end
    check("ready_latency", done_at, exp_lat);
    check("ce_count", ce_cnt, blk ? 0 : 1);
    check("err", err_s, blk);
    check("oe_at_done", oe_done, r);
    if (!blk) begin
      check("ce_cycle", ce_at, WS + 1);
      check("ram_we", we_s, !r);
      check("ram_addr", ra, a);
      if (!r) check("ram_wdata", rw, d);
    end
    if (r) begin
      exp_rd = exp_q.pop_front();
      check("rdata", rd, exp_rd);
    end
    @(negedge clk);
    check("ready_one_cycle", ready, 0);
    check("ce_after_done", ram_ce, 0);
    check("oe_hold", rdata_oe, r);
  endtask

  initial begin
    logic        bad;
    logic        r;
    logic [11:0] a;
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[12'h123]    = 16'hBEEF;
    ref_mem[12'h123] = 16'hBEEF;
    ram_rdata = '0;

    // reset held with a request pending: nothing may move
    reset = 1'b0; memrq = 1'b1; rnw = 1'b1; addr = 12'h123; wdata = '0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ram_ce | ready | rdata_oe | err) bad = 1'b1;
    end
    check("reset_quiet", bad, 0);
    check("reset_state", dbg_state, 0);
    check("reset_rdata", rdata, 0);
    check("reset_ram_addr", ram_addr, 0);
    reset = 1'b1;
    do_txn(1'b1, 12'h123, 16'h0, 1'b0);   // first IDLE edge accepts; expects BEEF

    // write then read back, and a dropped request completing from latches
    do_txn(1'b0, 12'h3FF, 16'h5A5A, 1'b0);
    do_txn(1'b1, 12'h3FF, 16'h0, 1'b0);
    do_txn(1'b0, 12'h200, 16'hC3C3, 1'b1);
    do_txn(1'b1, 12'h200, 16'h0, 1'b1);

`ifdef MEM_ROM_PROTECT_EN
    do_txn(1'b0, 12'h0FF, 16'hFFFF, 1'b0);
    check("rom_untouched", sram[12'h0FF], ref_mem[12'h0FF]);
    do_txn(1'b1, 12'h0FF, 16'h0, 1'b0);
    do_txn(1'b0, 12'h100, 16'h1111, 1'b0);
    do_txn(1'b1, 12'h100, 16'h0, 1'b0);
`endif

    // reset during WAIT discards the write
    memrq = 1'b1; rnw = 1'b0; addr = 12'h2AA; wdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; memrq = 1'b0;
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ram_ce | ready) bad = 1'b1;
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ram_ce | ready) bad = 1'b1;
    end
    check("midrst_quiet", bad, 0);
    check("midrst_state", dbg_state, 0);
    do_txn(1'b1, 12'h2AA, 16'h0, 1'b0);

    // randomized back-to-back traffic around the ROM boundary
    for (int k = 0; k < 40; k++) begin
      r = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) != 0) ? 12'($urandom_range(0, 4095))
                                      : 12'h0F0 + 12'($urandom_range(0, 31));
      do_txn(r, a, 16'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    memrq = 1'b0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
